// File: rtl/step_sched.sv
// Step-pulse scheduler: fixed-width step pulses, direction setup delay, limited accel ramp, signed position count.
// Outputs are registered; first rise one clk after a start request; inputs are sampled only at period boundaries.
module step_sched #(
    parameter int WIDTH_N      = 24,
    parameter int PULSE_W      = 100,
    parameter int DIR_SETUP    = 250,
    parameter int MIN_PERIOD   = 500,
    parameter int START_PERIOD = 50000,
    parameter int RAMP_DELTA   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               dir_req,
    input  logic [WIDTH_N-1:0] period_req,
    input  logic               pos_clr,
    output logic               step_out,
    output logic               dir_out,
    output logic               busy,
    output logic [WIDTH_N-1:0] per_cur,
    output logic [31:0]        pos_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIR_WAIT = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;

    localparam int TW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    localparam logic [WIDTH_N-1:0] MIN_P   = WIDTH_N'(MIN_PERIOD);
    localparam logic [WIDTH_N-1:0] START_P = WIDTH_N'(START_PERIOD);
    localparam logic [WIDTH_N-1:0] RAMP_P  = WIDTH_N'(RAMP_DELTA);
    localparam logic [WIDTH_N-1:0] PULSE_P = WIDTH_N'(PULSE_W);
    localparam logic [TW-1:0]      TIMER_INIT = TW'(DIR_SETUP - 1);

    logic [1:0]         state_q, state_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic [WIDTH_N-1:0] per_q, per_d;
    logic [WIDTH_N-1:0] phase_q, phase_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [31:0]        pos_q, pos_d;

    logic [WIDTH_N-1:0] tgt;
    logic [WIDTH_N-1:0] start_per;
    logic               run_ok;
    logic               do_start;
    logic               step_rise;

    always_comb begin
        tgt       = (period_req < MIN_P) ? MIN_P : period_req;
        start_per = (tgt > START_P) ? tgt : START_P;
        run_ok    = enable && (period_req != '0);

        state_d  = state_q;
        dir_d    = dir_q;
        per_d    = per_q;
        phase_d  = phase_q;
        timer_d  = timer_q;
        do_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                do_start = run_ok;
            end
            S_DIR_WAIT: begin
                if (!run_ok) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    do_start = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_RUN: begin
                if (phase_q == per_q - WIDTH_N'(1)) begin
                    if (!run_ok) begin
                        state_d = S_IDLE;
                    end else if (dir_req != dir_q) begin
                        state_d = S_DIR_WAIT;
                        dir_d   = dir_req;
                        timer_d = TIMER_INIT;
                    end else begin
                        phase_d = '0;
                        // Speed-up is bounded per step; slowing down takes effect at once.
                        if (per_q > tgt) begin
                            per_d = (per_q - tgt > RAMP_P) ? per_q - RAMP_P : tgt;
                        end else begin
                            per_d = tgt;
                        end
                    end
                end else begin
                    phase_d = phase_q + WIDTH_N'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh start always re-runs the direction check, even after a completed setup wait.
        if (do_start) begin
            if (dir_req != dir_q) begin
                state_d = S_DIR_WAIT;
                dir_d   = dir_req;
                timer_d = TIMER_INIT;
            end else begin
                state_d = S_RUN;
                per_d   = start_per;
                phase_d = '0;
            end
        end

        step_d    = (state_d == S_RUN) && (phase_d < PULSE_P);
        busy_d    = (state_d != S_IDLE);
        step_rise = step_d && !step_q;

        if (pos_clr) begin
            pos_d = '0;
        end else if (step_rise) begin
            pos_d = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
        end else begin
            pos_d = pos_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            per_q   <= '0;
            phase_q <= '0;
            timer_q <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            per_q   <= per_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
        end
    end

    assign step_out  = step_q;
    assign dir_out   = dir_q;
    assign busy      = busy_q;
    assign per_cur   = per_q;
    assign pos_count = pos_q;

endmodule

// File: tb/tb_step_sched.sv
// Bench for step_sched: directed scenarios then random stimulus, every cycle compared with a timestamp-based model.
module tb_step_sched;

    localparam int WN   = 24;
    localparam int PW   = 4;
    localparam int DS   = 6;
    localparam int MINP = 10;
    localparam int STP  = 40;
    localparam int RD   = 8;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          dir_req;
    logic [WN-1:0] period_req;
    logic          pos_clr;
    logic          step_out;
    logic          dir_out;
    logic          busy;
    logic [WN-1:0] per_cur;
    logic [31:0]   pos_count;

    step_sched #(
        .WIDTH_N(WN), .PULSE_W(PW), .DIR_SETUP(DS),
        .MIN_PERIOD(MINP), .START_PERIOD(STP), .RAMP_DELTA(RD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir_req(dir_req),
        .period_req(period_req), .pos_clr(pos_clr),
        .step_out(step_out), .dir_out(dir_out), .busy(busy),
        .per_cur(per_cur), .pos_count(pos_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: mode plus absolute cycle stamps of the last rise and last direction change.
    int          cyc;
    int          m_mode;
    logic        m_dir;
    int          m_per;
    int          m_rise;
    int          m_dcyc;
    logic [31:0] m_pos;

    logic step_prev;
    bit   rose_seen;
    int   rises[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        cyc    = 0;
        m_mode = M_IDLE;
        m_dir  = 1'b0;
        m_per  = 0;
        m_rise = 0;
        m_dcyc = 0;
        m_pos  = '0;
    endfunction

    function automatic void model_edge();
        int  tgt;
        bit  go;
        bit  rose;
        bit  launch;
        tgt    = (int'(period_req) < MINP) ? MINP : int'(period_req);
        go     = enable && (period_req != 0);
        rose   = 0;
        launch = 0;
        cyc    = cyc + 1;
        if (m_mode == M_IDLE) begin
            launch = go;
        end else if (m_mode == M_WAIT) begin
            if (!go) m_mode = M_IDLE;
            else if (cyc - m_dcyc == DS) launch = 1;
        end else if (cyc - m_rise == m_per) begin
            if (!go) begin
                m_mode = M_IDLE;
            end else if (dir_req != m_dir) begin
                m_mode = M_WAIT; m_dir = dir_req; m_dcyc = cyc;
            end else begin
                m_rise = cyc; rose = 1;
                if (m_per > tgt) m_per = (m_per - RD > tgt) ? m_per - RD : tgt;
                else m_per = tgt;
            end
        end
        if (launch) begin
            if (dir_req != m_dir) begin
                m_mode = M_WAIT; m_dir = dir_req; m_dcyc = cyc;
            end else begin
                m_mode = M_RUN; m_per = (tgt > STP) ? tgt : STP;
                m_rise = cyc; rose = 1;
            end
        end
        if (pos_clr) m_pos = '0;
        else if (rose) m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
    endfunction

    task automatic check_all();
        logic exp_step;
        exp_step = (m_mode == M_RUN) && (cyc - m_rise < PW);
        chk("step_out",  32'(step_out), 32'(exp_step));
        chk("dir_out",   32'(dir_out),  32'(m_dir));
        chk("busy",      32'(busy),     32'(m_mode != M_IDLE));
        chk("per_cur",   32'(per_cur),  32'(m_per));
        chk("pos_count", pos_count,     m_pos);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        rose_seen = step_out && !step_prev;
        step_prev = step_out;
        if (rose_seen) rises.push_back(cyc);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rise();
        bit got;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            got = rose_seen;
        end
        chk("wait_rise", 32'(got), 32'd1);
    endtask

    initial begin
        int t0;
        int n;
        rst = 1'b1; enable = 1'b0; dir_req = 1'b0; period_req = '0; pos_clr = 1'b0;
        step_prev = 1'b0; rose_seen = 0;
        model_reset();
        ticks(3);
        rst = 1'b0;
        ticks(2);

        // Start in the current direction, ramp 40 -> 20.
        rises.delete();
        t0 = cyc;
        enable = 1'b1; dir_req = 1'b0; period_req = 24'd20;
        ticks(160);
        chk("first_rise", 32'(rises[0] - t0), 32'd1);
        chk("space0", 32'(rises[1] - rises[0]), 32'd40);
        chk("space1", 32'(rises[2] - rises[1]), 32'd32);
        chk("space2", 32'(rises[3] - rises[2]), 32'd24);
        chk("space3", 32'(rises[4] - rises[3]), 32'd20);
        chk("space4", 32'(rises[5] - rises[4]), 32'd20);

        // Reverse mid-period.
        wait_rise();
        ticks(7);
        dir_req = 1'b1;
        ticks(120);
        chk("dir_after_rev", 32'(dir_out), 32'd1);

        // Clamp at MIN_PERIOD, then immediate deceleration.
        period_req = 24'd3;
        ticks(200);
        chk("per_clamped", 32'(per_cur), 32'd10);
        period_req = 24'd30;
        ticks(80);

        // Drop enable at phase 1 of a 20-cycle period.
        period_req = 24'd20;
        ticks(60);
        wait_rise();
        tick();
        enable = 1'b0;
        rises.delete();
        ticks(25);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_norise", 32'(rises.size()), 32'd0);

        // Async reset during a pulse.
        enable = 1'b1; dir_req = 1'b0;
        wait_rise();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_step", 32'(step_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", pos_count, 32'd0);
        chk("rst_dir", 32'(dir_out), 32'd0);
        model_reset();
        step_prev = 1'b0;
        ticks(2);
        rst = 1'b0;
        tick();
        chk("restart_step", 32'(step_out), 32'd1);

        // Clear coinciding with a step rise.
        pos_clr = 1'b1; dir_req = 1'b1; period_req = 24'd10;
        tick();
        pos_clr = 1'b0;
        for (int i = 0; i < 5; i++) wait_rise();
        chk("pos_five", pos_count, 32'd5);
        n = 0;
        while ((cyc + 1 - m_rise != m_per) && n < 100) begin
            tick();
            n++;
        end
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        chk("clr_step", 32'(step_out), 32'd1);
        chk("clr_pos", pos_count, 32'd0);

        // Two's complement wrap.
        enable = 1'b0;
        ticks(60);
        force dut.pos_q = 32'h7FFF_FFFF;
        m_pos = 32'h7FFF_FFFF;
        #1;
        release dut.pos_q;
        enable = 1'b1;
        tick();
        chk("wrap_pos", pos_count, 32'h8000_0000);

        // Random stimulus.
        for (int it = 0; it < 120; it++) begin
            int hold;
            enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 30) dir_req = ~dir_req;
            case ($urandom_range(0, 9))
                0:       period_req = '0;
                1:       period_req = WN'($urandom_range(1, 12));
                default: period_req = WN'($urandom_range(10, 60));
            endcase
            hold = $urandom_range(1, 60);
            for (int k = 0; k < hold; k++) begin
                pos_clr = ($urandom_range(0, 99) < 3);
                tick();
            end
            pos_clr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
